load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- MEM-stage initiator that turns pipeline load/store requests into word-wide, big-endian accesses on the data-memory bus.
- Handles byte, halfword and word sizes: alignment checks, byte-lane enables, store-data replication, load-data extraction with sign/zero extension.
- Stalls the pipeline until the memory acknowledges the access, or until a timeout expires.
- Sits between the EX/MEM pipeline register and the data memory.

Parameters:
TIMEOUT, 16, maximum cycles spent in REQ waiting for MemAck before abort (>=2)
CNT_W, 5, width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT)

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
MemRead  input  1  pipeline load request
MemWrite  input  1  pipeline store request (wins if both MemRead and MemWrite are high)
Size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
Unsigned  input  1  loads only: 1 zero-extends, 0 sign-extends
Address  input  32  byte address
WriteData  input  32  store data; byte/half taken from the low bits
ReadData  output  32  extended load result, registered
Stall  output  1  holds the pipeline while an access is in flight
Misaligned  output  1  one-cycle pulse on an alignment fault
BusError  output  1  one-cycle pulse on a timeout
MemReq  output  1  memory request, held high until ack
MemWe  output  1  1 = write
MemAddr  output  32  word address, bits [1:0] forced to 00
MemWData  output  32  lane-replicated store data
MemByteEn  output  4  lane enables; bit3 = bits[31:24] = byte offset 0 (big-endian)
MemRData  input  32  memory read word, valid when MemAck=1
MemAck  input  1  memory completion, single-cycle

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - FSM=IDLE; counter=0.
  - ReadData, MemAddr, MemWData all 0; MemByteEn=0.
  - MemReq, MemWe, Misaligned, BusError all 0.
- FSM states: IDLE, REQ, DONE.
- Alignment fault: Size=01 with Address[0]=1, or Size=10/11 with Address[1:0]!=0.
- IDLE:
  - Request (MemRead|MemWrite) and aligned: latch type, size, offset=Address[1:0], Unsigned, MemAddr, MemWData, MemByteEn; assert MemReq/MemWe registered; go to REQ. Stall is combinationally 1 in this cycle.
  - Request but misaligned: Misaligned=1 for the next cycle only; stay IDLE; no memory access; Stall=0; ReadData unchanged.
  - MemAck in IDLE is ignored.
- Byte enables:
  - byte: 1000 >> offset
  - half: offset 0 -> 1100, offset 2 -> 0011
  - word: 1111
- Store data: byte -> {4{WriteData[7:0]}}; half -> {2{WriteData[15:0]}}; word -> WriteData.
- REQ:
  - Stall=1; MemReq and MemAddr/MemWData/MemByteEn/MemWe held stable; counter increments each cycle.
  - On MemAck: MemReq drops on the next edge.
    - Read: ReadData <= extended data. Byte = MemRData[31-8*offset -: 8]; half = MemRData[31-8*offset -: 16]; sign- or zero-extended per Unsigned.
    - Write: ReadData unchanged.
    - Go to DONE.
  - If counter reaches TIMEOUT-1 with no ack: drop MemReq, pulse BusError for 1 cycle, go to DONE. ReadData unchanged.
- DONE:
  - Stall=0, so the pipeline advances on this edge.
  - Requests are not sampled, so the same instruction is never relaunched.
  - Next state is IDLE.
- Latency: a load acked N cycles after MemReq rises produces ReadData valid in DONE, with Stall high for N+1 cycles. Minimum is N=1, giving 2 stall cycles.
- Counter clears on every entry to REQ.
- Reset mid-REQ: MemReq drops asynchronously and no pulses are generated.

Test Plan:
1. Word load, mem word at 0x100 = 0x8899AABB, MemAck 2 cycles after MemReq -> MemAddr=0x100, MemByteEn=1111, Stall high 3 cycles, ReadData=0x8899AABB in DONE.
2. Byte loads from 0x102 on the same word, Unsigned=0 then 1 -> MemByteEn=0010, ReadData=0xFFFFFFAA then 0x000000AA.
3. Half store 0x1234CAFE to 0x206 -> MemAddr=0x204, MemByteEn=0011, MemWData=0xCAFECAFE, MemWe=1; ReadData unchanged.
4. Word load from 0x101, and half load from 0x103 -> Misaligned one-cycle pulse each, MemReq never rises, Stall=0.
5. Load with MemAck never asserted, TIMEOUT=16 -> MemReq high exactly 16 cycles, BusError pulse 1 cycle, FSM back to IDLE; stray MemAck afterwards ignored.
6. Rst_n low mid-REQ -> MemReq/Stall drop without waiting for Clk, all outputs at reset values; a word store after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator for a big-endian word-wide data bus
module load_store_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Misaligned,
    output logic        BusError,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemByteEn,
    input  logic [31:0] MemRData,
    input  logic        MemAck
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               lat_read;
    logic [1:0]         lat_size;
    logic [1:0]         lat_off;
    logic               lat_uns;

    logic               req_in;
    logic               misalign;
    logic               launch;
    logic               timeout;
    logic [3:0]         be_nxt;
    logic [31:0]        wdata_nxt;
    logic [31:0]        shifted;
    logic [31:0]        load_ext;

    assign req_in  = MemRead | MemWrite;
    assign launch  = (state == IDLE) && req_in && !misalign;
    assign timeout = (cnt == CNT_W'(TIMEOUT - 1));
    // Reset gating keeps Stall low while Rst_n is held, even if a request is pending.
    assign Stall   = Rst_n & (launch | (state == REQ));

    always_comb begin
        misalign  = 1'b0;
        be_nxt    = 4'b1111;
        wdata_nxt = WriteData;
        case (Size)
            2'b00: begin
                be_nxt    = 4'b1000 >> Address[1:0];
                wdata_nxt = {4{WriteData[7:0]}};
            end
            2'b01: begin
                misalign  = Address[0];
                be_nxt    = Address[1] ? 4'b0011 : 4'b1100;
                wdata_nxt = {2{WriteData[15:0]}};
            end
            default: misalign = |Address[1:0];
        endcase
    end

    // Byte offset 0 lives in bits [31:24], so shift the addressed lane to the top.
    always_comb begin
        shifted  = MemRData << {lat_off, 3'b000};
        load_ext = MemRData;
        case (lat_size)
            2'b00:   load_ext = {{24{~lat_uns & shifted[31]}}, shifted[31:24]};
            2'b01:   load_ext = {{16{~lat_uns & shifted[31]}}, shifted[31:16]};
            default: load_ext = MemRData;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = REQ;
            REQ:     if (MemAck || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_read   <= 1'b0;
            lat_size   <= 2'b00;
            lat_off    <= 2'b00;
            lat_uns    <= 1'b0;
            ReadData   <= '0;
            MemAddr    <= '0;
            MemWData   <= '0;
            MemByteEn  <= '0;
            MemReq     <= 1'b0;
            MemWe      <= 1'b0;
            Misaligned <= 1'b0;
            BusError   <= 1'b0;
        end else begin
            state      <= state_nxt;
            Misaligned <= (state == IDLE) && req_in && misalign;
            BusError   <= (state == REQ) && !MemAck && timeout;
            if (launch) begin
                cnt       <= '0;
                lat_read  <= !MemWrite;
                lat_size  <= Size;
                lat_off   <= Address[1:0];
                lat_uns   <= Unsigned;
                MemAddr   <= {Address[31:2], 2'b00};
                MemWData  <= wdata_nxt;
                MemByteEn <= be_nxt;
                MemReq    <= 1'b1;
                MemWe     <= MemWrite;
            end else if (state == REQ) begin
                cnt <= cnt + 1'b1;
                if (MemAck || timeout) begin
                    MemReq <= 1'b0;
                end
                if (MemAck && lat_read) begin
                    ReadData <= load_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Unsigned = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Misaligned;
    logic        BusError;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemByteEn;
    logic [31:0] MemRData = '0;
    logic        MemAck = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
        logic [31:0] rd;
        int          stall;
        int          reqcyc;
        logic        berr;
    } exp_t;

    exp_t sb[$];

    load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Size(Size), .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .Misaligned(Misaligned), .BusError(BusError),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemByteEn(MemByteEn), .MemRData(MemRData), .MemAck(MemAck)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] mrd, input int ack_n,
                          input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd,
                          input logic [31:0] e_rd, input int e_stall, input logic e_berr);
        exp_t e;
        exp_t got;
        int st;
        int rq;
        logic [31:0] s_addr;
        logic [31:0] s_wd;
        logic [3:0]  s_be;
        logic        s_we;
        e = '{e_addr, e_be, e_wd, wr, e_rd, e_stall, (e_berr ? TIMEOUT : ack_n), e_berr};
        sb.push_back(e);
        s_addr = 'x; s_wd = 'x; s_be = 'x; s_we = 'x;
        @(negedge Clk);
        MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns; Address = addr; WriteData = wd;
        #1;
        st = 0;
        rq = 0;
        for (int c = 0; c < 64 && Stall; c++) begin
            st++;
            if (MemReq) begin
                rq++;
                s_addr = MemAddr; s_wd = MemWData; s_be = MemByteEn; s_we = MemWe;
                if (rq == ack_n) begin
                    MemAck = 1'b1;
                    MemRData = mrd;
                end
            end
            @(negedge Clk);
            MemAck = 1'b0;
            #1;
        end
        got = sb.pop_front();
        check({tag, ".stall"}, st, got.stall);
        check({tag, ".reqcyc"}, rq, got.reqcyc);
        check({tag, ".addr"}, s_addr, got.addr);
        check({tag, ".be"}, {28'd0, s_be}, {28'd0, got.be});
        check({tag, ".wdata"}, s_wd, got.wd);
        check({tag, ".we"}, {31'd0, s_we}, {31'd0, got.we});
        check({tag, ".rdata"}, ReadData, got.rd);
        check({tag, ".buserr"}, {31'd0, BusError}, {31'd0, got.berr});
        check({tag, ".req_done"}, {31'd0, MemReq}, 32'd0);
        MemRead = 1'b0;
        MemWrite = 1'b0;
        @(negedge Clk);
        #1;
        check({tag, ".idle_stall"}, {31'd0, Stall}, 32'd0);
        check({tag, ".idle_buserr"}, {31'd0, BusError}, 32'd0);
    endtask

    task automatic misaligned_req(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                                  input logic [31:0] e_rd);
        @(negedge Clk);
        MemRead = 1'b1; Size = sz; Address = addr;
        #1;
        check({tag, ".stall"}, {31'd0, Stall}, 32'd0);
        @(negedge Clk);
        MemRead = 1'b0;
        #1;
        check({tag, ".pulse"}, {31'd0, Misaligned}, 32'd1);
        check({tag, ".noreq"}, {31'd0, MemReq}, 32'd0);
        @(negedge Clk);
        #1;
        check({tag, ".pulse_end"}, {31'd0, Misaligned}, 32'd0);
        check({tag, ".noreq2"}, {31'd0, MemReq}, 32'd0);
        check({tag, ".rdata"}, ReadData, e_rd);
    endtask

    initial begin
        #12;
        check("rst.rdata", ReadData, 32'd0);
        check("rst.req", {31'd0, MemReq}, 32'd0);
        check("rst.be", {28'd0, MemByteEn}, 32'd0);
        check("rst.addr", MemAddr, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        access("wld", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'h8899AABB, 2,
               32'h100, 4'b1111, 32'h0, 32'h8899AABB, 3, 0);
        access("bld_s", 1, 0, 2'b00, 0, 32'h102, 32'h0, 32'h8899AABB, 2,
               32'h100, 4'b0010, 32'h0, 32'hFFFFFFAA, 3, 0);
        access("bld_u", 1, 0, 2'b00, 1, 32'h102, 32'h0, 32'h8899AABB, 2,
               32'h100, 4'b0010, 32'h0, 32'h000000AA, 3, 0);
        access("hld_s", 1, 0, 2'b01, 0, 32'h100, 32'h0, 32'h8899AABB, 1,
               32'h100, 4'b1100, 32'h0, 32'hFFFF8899, 2, 0);
        access("hst", 0, 1, 2'b01, 0, 32'h206, 32'h1234CAFE, 32'h0, 1,
               32'h204, 4'b0011, 32'hCAFECAFE, 32'hFFFF8899, 2, 0);

        misaligned_req("mis_w", 2'b10, 32'h101, 32'hFFFF8899);
        misaligned_req("mis_h", 2'b01, 32'h103, 32'hFFFF8899);

        access("tmo", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'h0, 0,
               32'h100, 4'b1111, 32'h0, 32'hFFFF8899, TIMEOUT + 1, 1);
        @(negedge Clk);
        MemAck = 1'b1;
        MemRData = 32'h55555555;
        #1;
        check("stray.stall", {31'd0, Stall}, 32'd0);
        @(negedge Clk);
        MemAck = 1'b0;
        #1;
        check("stray.req", {31'd0, MemReq}, 32'd0);
        check("stray.rdata", ReadData, 32'hFFFF8899);

        @(negedge Clk);
        MemRead = 1'b1; Size = 2'b10; Address = 32'h100;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        check("mid.req_up", {31'd0, MemReq}, 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("mid.req", {31'd0, MemReq}, 32'd0);
        check("mid.stall", {31'd0, Stall}, 32'd0);
        check("mid.rdata", ReadData, 32'd0);
        check("mid.addr", MemAddr, 32'd0);
        check("mid.be", {28'd0, MemByteEn}, 32'd0);
        MemRead = 1'b0;
        @(negedge Clk);
        #1;
        check("mid.pulses", {30'd0, Misaligned, BusError}, 32'd0);
        Rst_n = 1'b1;

        access("wst", 0, 1, 2'b11, 0, 32'h300, 32'hDEADBEEF, 32'h0, 3,
               32'h300, 4'b1111, 32'hDEADBEEF, 32'h0, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
